// File: rtl/compute_module.sv
`default_nettype none
// ============================================================================
// Module   : compute_module
// Brief    : Keypad calculator sequencer; optional COMPUTE_EDGE_DETECT_EN.
// Revision : 1.0
// ============================================================================
module compute_module (
    input  logic clk,
    input  logic rst,
    input  logic enter,
    input  logic number,
    input  logic total,
    input  logic clear,
    input  logic valid,
    output logic update,
    output logic show,
    output logic store,
    output logic reset
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRST     = 3'd1,
        WAIT_NEXT = 3'd2,
        NEXT      = 3'd3,
        SHOWING   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_update, r_show, r_store, r_reset;
    logic   w_update, w_store, w_reset;
    logic   w_p_enter, w_p_number, w_p_total, w_p_clear;

`ifdef COMPUTE_EDGE_DETECT_EN
    logic r_enter_d, r_number_d, r_total_d, r_clear_d;

    // History follows the keys during reset so a held key is not a press.
    always_ff @(posedge clk) begin
        r_enter_d  <= enter;
        r_number_d <= number;
        r_total_d  <= total;
        r_clear_d  <= clear;
    end

    assign w_p_enter  = enter  & ~r_enter_d;
    assign w_p_number = number & ~r_number_d;
    assign w_p_total  = total  & ~r_total_d;
    assign w_p_clear  = clear  & ~r_clear_d;
`else
    assign w_p_enter  = enter;
    assign w_p_number = number;
    assign w_p_total  = total;
    assign w_p_clear  = clear;
`endif

    // Priority clear > total > number > enter; lower presses are dropped.
    always_comb begin
        w_next   = r_state;
        w_update = 1'b0;
        w_store  = 1'b0;
        w_reset  = 1'b0;
        if (w_p_clear) begin
            w_reset = 1'b1;
            w_next  = IDLE;
        end else if (w_p_total) begin
            if (r_state == FIRST || r_state == NEXT || r_state == SHOWING)
                w_next = SHOWING;
        end else if (w_p_number) begin
            if (r_state == FIRST || r_state == NEXT || r_state == SHOWING)
                w_next = WAIT_NEXT;
        end else if (w_p_enter && valid) begin
            case (r_state)
                IDLE, SHOWING: begin
                    w_store = 1'b1;
                    w_next  = FIRST;
                end
                WAIT_NEXT: begin
                    w_update = 1'b1;
                    w_next   = NEXT;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_update <= 1'b0;
            r_show   <= 1'b0;
            r_store  <= 1'b0;
            r_reset  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_update <= w_update;
            r_show   <= (w_next == SHOWING);
            r_store  <= w_store;
            r_reset  <= w_reset;
        end
    end

    assign update = r_update;
    assign show   = r_show;
    assign store  = r_store;
    assign reset  = r_reset;

endmodule
`default_nettype wire

// File: tb/tb_compute_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_compute_module
// Brief    : Directed self-checking bench for compute_module.
// Revision : 1.0
// ============================================================================
module tb_compute_module;

    logic clk = 1'b0;
    logic rst, enter, number, total, clear, valid;
    logic update, show, store, reset;
    logic [3:0] w_outs;
    int   n_checks = 0;
    int   n_fail   = 0;

    compute_module u_dut (
        .clk    (clk),
        .rst    (rst),
        .enter  (enter),
        .number (number),
        .total  (total),
        .clear  (clear),
        .valid  (valid),
        .update (update),
        .show   (show),
        .store  (store),
        .reset  (reset)
    );

    always #5 clk = ~clk;

    // Output vector order: {update, show, store, reset}
    assign w_outs = {update, show, store, reset};

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got u/sh/st/rs=%b expected %b", tag, got, exp);
        end
    endtask

    // keys = {clear, total, number, enter}; called at a negedge.
    task automatic step(input string tag, input logic [3:0] keys, input logic v,
                        input logic [3:0] exp);
        {clear, total, number, enter} = keys;
        valid = v;
        @(negedge clk);
        check(tag, w_outs, exp);
        {clear, total, number, enter} = 4'b0000;
        valid = 1'b0;
`ifdef COMPUTE_EDGE_DETECT_EN
        @(negedge clk);
`endif
    endtask

    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_ENT  = 4'b0001;
    localparam logic [3:0] K_NUM  = 4'b0010;
    localparam logic [3:0] K_TOT  = 4'b0100;
    localparam logic [3:0] K_CLR  = 4'b1000;

    initial begin
        rst = 1'b1;
        {clear, total, number, enter} = 4'b0000;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", w_outs, 4'b0000);
        rst = 1'b0;

        // Full sequence
        step("first_store",    K_ENT, 1'b1, 4'b0010);
        step("store_one_cyc",  K_NONE, 1'b0, 4'b0000);
        step("number_nostb",   K_NUM, 1'b0, 4'b0000);
        step("update",         K_ENT, 1'b1, 4'b1000);
        step("total_show",     K_TOT, 1'b0, 4'b0100);
        step("show_held",      K_NONE, 1'b0, 4'b0100);
        step("store_from_shw", K_ENT, 1'b1, 4'b0010);
        step("clear_first",    K_CLR, 1'b0, 4'b0001);

        // valid=0 and ignored keys
        step("ent_nv_idle",    K_ENT, 1'b0, 4'b0000);
        step("tot_idle",       K_TOT, 1'b0, 4'b0000);
        step("ent_after_nv",   K_ENT, 1'b1, 4'b0010);
        step("num_to_wait",    K_NUM, 1'b0, 4'b0000);
        step("tot_wait",       K_TOT, 1'b0, 4'b0000);
        step("ent_nv_wait",    K_ENT, 1'b0, 4'b0000);
        step("ent_v_wait",     K_ENT, 1'b1, 4'b1000);

        // Simultaneous clear+enter+total in NEXT
        step("clr_ent_tot",    K_CLR | K_ENT | K_TOT, 1'b1, 4'b0001);
        step("tot_after_clr",  K_TOT, 1'b0, 4'b0000);

        // number from SHOWING, total in SHOWING, clear in SHOWING
        step("s_store",        K_ENT, 1'b1, 4'b0010);
        step("s_total",        K_TOT, 1'b0, 4'b0100);
        step("s_number",       K_NUM, 1'b0, 4'b0000);
        step("s_update",       K_ENT, 1'b1, 4'b1000);
        step("s_total2",       K_TOT, 1'b0, 4'b0100);
        step("s_total_again",  K_TOT, 1'b0, 4'b0100);
        step("s_clear",        K_CLR, 1'b0, 4'b0001);

        // number beats enter; enter discarded, state WAIT_NEXT
        step("p_store",        K_ENT, 1'b1, 4'b0010);
        step("p_num_ent",      K_NUM | K_ENT, 1'b1, 4'b0000);
        step("p_update",       K_ENT, 1'b1, 4'b1000);
        step("p_clear",        K_CLR, 1'b0, 4'b0001);

        // rst overrides a press in the same cycle
        rst = 1'b1;
        step("rst_with_ent",   K_ENT, 1'b1, 4'b0000);
        rst = 1'b0;
        step("tot_after_rst",  K_TOT, 1'b0, 4'b0000);

`ifdef COMPUTE_EDGE_DETECT_EN
        begin
            int n_store;
            n_store = 0;
            enter = 1'b1;
            valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (store) n_store++;
            end
            enter = 1'b0;
            valid = 1'b0;
            @(negedge clk);
            if (store) n_store++;
            check("held_ent_stores", n_store[3:0], 4'd1);
            step("e_clear", K_CLR, 1'b0, 4'b0001);

            n_store = 0;
            rst   = 1'b1;
            enter = 1'b1;
            valid = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (store) n_store++;
            end
            enter = 1'b0;
            valid = 1'b0;
            @(negedge clk);
            check("held_over_rst", n_store[3:0], 4'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/compute_module.md
# compute_module

Sequencing controller of the four-function keypad calculator datapath. It turns the operator keys (enter, number, total, clear) into single-cycle command strobes for the execution datapath: store, update and reset, plus a held show level. It sits between the key-conditioning controller and the execution/accumulator block, and gates every command on the input module's `valid` flag.

## Interface
Parameters: none.

Ports:
- `clk` — input, 1 — system clock. One clock; reset is synchronous and active-high.
- `rst` — input, 1 — synchronous, active-high reset.
- `enter` — input, 1 — enter key.
- `number` — input, 1 — next-operand key.
- `total` — input, 1 — show-result key.
- `clear` — input, 1 — clear key.
- `valid` — input, 1 — input module holds a legal entered operand.
- `update` — output, 1 — one-cycle strobe: combine the entered operand into the accumulator.
- `show` — output, 1 — level: drive the result display.
- `store` — output, 1 — one-cycle strobe: load the entered operand as the new first operand.
- `reset` — output, 1 — one-cycle strobe: clear the datapath.

## Operation
- States:
  - IDLE: no operand.
  - FIRST: first operand stored.
  - WAIT_NEXT: number pressed, awaiting operand.
  - NEXT: operand accumulated.
  - SHOWING: result displayed.
- A "press" is one event per key (see Configuration). Simultaneous presses are resolved by priority: clear > total > number > enter. Only the highest-priority press acts; the others in that cycle are discarded.
- clear, in any state: pulse `reset`, go to IDLE, drop `show`.
- enter:
  - with `valid`=1 in IDLE or SHOWING: pulse `store`, go to FIRST, drop `show`.
  - with `valid`=1 in WAIT_NEXT: pulse `update`, go to NEXT.
  - with `valid`=0, or in FIRST/NEXT: ignored, no strobe, state unchanged.
- number:
  - in FIRST or NEXT: go to WAIT_NEXT, no strobe.
  - in SHOWING: go to WAIT_NEXT and drop `show`, so the displayed result becomes the first operand.
  - otherwise: ignored.
- total:
  - in FIRST or NEXT: go to SHOWING and assert `show`.
  - in SHOWING: stays in SHOWING, `show` stays high.
  - otherwise: ignored.
- Outputs are fully registered. `store`, `update` and `reset` are mutually exclusive and never high for two consecutive cycles from a single press.
- `show` is high exactly while the state is SHOWING.

## Timing
- While `rst`=1:
  - state is IDLE.
  - `update`, `show`, `store` and `reset` are all 0.
  - the key history registers load the current key values, so a key held across reset release is not seen as a press.
- Latency: a press sampled at rising edge N produces its strobe, or the `show` change, during cycle N+1. A strobe lasts exactly one cycle.
- `valid` is sampled at the same edge as the enter press.
- A press in the cycle right after another press is processed normally; strobes may then appear back to back from distinct presses.
- `rst` asserted mid-operation overrides any pending press in the same cycle. No strobe is emitted.

## Configuration
- `COMPUTE_EDGE_DETECT_EN`
  - Defined: keys are treated as levels. A press is a rising edge, detected against a registered copy of each key. A key held high for many cycles yields one press.
  - Undefined: keys are treated as single-cycle pulses from the controller. Every cycle a key is high counts as a press, and no history registers are built.

## Test plan
- Reset: hold `rst` 3 cycles with all keys 0 → all outputs 0. Then enter (valid=1) → `store`=1 for one cycle, one cycle after the press.
- Full sequence: enter(valid) → `store`; number → no strobe; enter(valid) → `update`; total → `show` goes to 1 and stays; enter(valid) → `store` and `show` goes to 0.
- enter with valid=0 in IDLE and in WAIT_NEXT → no strobe, state unchanged. A following enter with valid=1 in WAIT_NEXT → `update`.
- Simultaneous clear+enter+total in NEXT → `reset` only, `show` stays 0. A following total → ignored (IDLE).
- With `COMPUTE_EDGE_DETECT_EN`: enter held 10 cycles → exactly one `store`. Enter held across `rst` release → no strobe.
- total in IDLE and in WAIT_NEXT → `show` stays 0. Clear during SHOWING → `reset` pulse and `show` goes to 0 the same cycle.
